// File: rtl/masked_gf16_mul_pipe_if.sv
// Operand, randomness and result channels of the masked GF(2^4) multiplier.
// A master drives operands and randomness and consumes results; the slave is the multiplier.
interface masked_gf16_mul_pipe_if #(
  parameter int unsigned SHARES = 2
) ();
  localparam int unsigned NRND = SHARES * (SHARES - 1) / 2;

  logic                  in_valid;
  logic                  in_ready;
  logic [4*SHARES-1:0]   in_x;
  logic [4*SHARES-1:0]   in_y;
  logic                  rnd_valid;
  logic                  rnd_ready;
  logic [4*NRND-1:0]     rnd;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*SHARES-1:0]   out_z;

  modport master (
    output in_valid, in_x, in_y, rnd_valid, rnd, out_ready,
    input  in_ready, rnd_ready, out_valid, out_z
  );

  modport slave (
    input  in_valid, in_x, in_y, rnd_valid, rnd, out_ready,
    output in_ready, rnd_ready, out_valid, out_z
  );
endinterface

// File: rtl/masked_gf16_mul_pipe.sv
// d+1-share masked GF(2^4) multiplier (x^4+x+1), DOM-indep style, with a two-stage
// elastic pipeline: refreshed cross products registered in stage 1, compressed in stage 2.
module masked_gf16_mul_pipe #(
  parameter int unsigned SHARES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  masked_gf16_mul_pipe_if.slave  bus
);
  localparam int unsigned NRND = SHARES * (SHARES - 1) / 2;
  localparam int unsigned TW   = 4 * SHARES * SHARES;
  localparam int unsigned ZW   = 4 * SHARES;

  if (SHARES < 2 || SHARES > 4 || $bits(bus.in_x) != ZW || $bits(bus.rnd) != 4 * NRND)
  begin : g_bad_config
    $error("masked_gf16_mul_pipe: SHARES must be 2..4 and match the interface");
  end

  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] s;
    p = '0;
    s = a;
    for (int unsigned n = 0; n < 4; n++) begin
      if (b[n]) p = p ^ s;
      s = {s[2:0], 1'b0} ^ (s[3] ? 4'h3 : 4'h0);
    end
    return p;
  endfunction

  // Lexicographic index of pair (a,b), a<b: (0,1),(0,2),...,(1,2),...
  function automatic int unsigned pair_idx(input int unsigned a, input int unsigned b);
    return a * SHARES - (a * (a + 1)) / 2 + (b - a - 1);
  endfunction

  logic          s1_valid;
  logic          out_valid_q;
  logic [TW-1:0] t_q;
  logic [TW-1:0] t_d;
  logic [ZW-1:0] z_q;
  logic [ZW-1:0] z_d;
  logic          en1;
  logic          en2;
  logic          fire;

  assign en2           = ~out_valid_q | bus.out_ready;
  assign en1           = ~s1_valid | en2;
  assign bus.in_ready  = bus.rnd_valid & en1 & ~rst;
  assign fire          = bus.in_valid & bus.in_ready;
  assign bus.rnd_ready = fire;
  assign bus.out_valid = out_valid_q;
  assign bus.out_z     = z_q;

  always_comb begin
    t_d = '0;
    for (int unsigned i = 0; i < SHARES; i++) begin
      for (int unsigned j = 0; j < SHARES; j++) begin
        t_d[4*(i*SHARES+j) +: 4] = gf_mul(bus.in_x[4*i +: 4], bus.in_y[4*j +: 4]);
        if (i < j)
          t_d[4*(i*SHARES+j) +: 4] = t_d[4*(i*SHARES+j) +: 4] ^ bus.rnd[4*pair_idx(i, j) +: 4];
        else if (i > j)
          t_d[4*(i*SHARES+j) +: 4] = t_d[4*(i*SHARES+j) +: 4] ^ bus.rnd[4*pair_idx(j, i) +: 4];
      end
    end
  end

  // Compression reads only the registered cross products.
  always_comb begin
    z_d = '0;
    for (int unsigned i = 0; i < SHARES; i++) begin
      for (int unsigned j = 0; j < SHARES; j++) begin
        z_d[4*i +: 4] = z_d[4*i +: 4] ^ t_q[4*(i*SHARES+j) +: 4];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      out_valid_q <= 1'b0;
      t_q         <= '0;
      z_q         <= '0;
    end else begin
      if (en1) s1_valid <= fire;
      if (fire & en1) t_q <= t_d;
      if (en2) out_valid_q <= s1_valid;
      if (s1_valid & en2) z_q <= z_d;
    end
  end
endmodule

// File: tb/tb_masked_gf16_mul_pipe.sv
// Bench for masked_gf16_mul_pipe: directed vectors plus an occupancy/product model
// checked against the 3-share instance every cycle; a 2-share instance gets a fixed vector.
module tb_masked_gf16_mul_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  masked_gf16_mul_pipe_if #(.SHARES(3)) b ();
  masked_gf16_mul_pipe_if #(.SHARES(2)) b2 ();

  masked_gf16_mul_pipe #(.SHARES(3)) dut3 (.clk(clk), .rst(rst), .bus(b.slave));
  masked_gf16_mul_pipe #(.SHARES(2)) dut2 (.clk(clk), .rst(rst), .bus(b2.slave));

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference product: carry-less multiply then polynomial long division.
  function automatic logic [3:0] gf_ref(input logic [3:0] a, input logic [3:0] c);
    logic [6:0] p;
    p = '0;
    for (int i = 0; i < 4; i++) if (c[i]) p = p ^ (7'({3'b000, a}) << i);
    for (int k = 6; k >= 4; k--) if (p[k]) p = p ^ (7'b0010011 << (k - 4));
    return p[3:0];
  endfunction

  function automatic logic [3:0] unmask3(input logic [11:0] v);
    return v[3:0] ^ v[7:4] ^ v[11:8];
  endfunction

  // Model: queue of in-flight products with their pipeline depth (1 = stage 1, 2 = output).
  typedef struct { logic [3:0] prod; int age; } item_t;
  item_t q[$];
  logic        stall_prev = 1'b0;
  logic        rst_prev   = 1'b0;
  logic [11:0] last_z     = '0;

  always @(negedge clk) begin
    logic exp_ir, exp_ov, exp_fire;
    item_t it;
    exp_ir   = b.rnd_valid && !rst && (q.size() < 2 || b.out_ready);
    exp_ov   = (q.size() > 0) && (q[0].age == 2);
    exp_fire = exp_ir && b.in_valid;
    check("in_ready", int'(b.in_ready), int'(exp_ir));
    check("rnd_ready", int'(b.rnd_ready), int'(exp_fire));
    check("out_valid", int'(b.out_valid), int'(exp_ov));
    if (rst_prev) check("out_z_reset", int'(b.out_z), 0);
    if (exp_ov) check("out_z_product", int'(unmask3(b.out_z)), int'(q[0].prod));
    if (exp_ov && stall_prev) check("out_z_hold", int'(b.out_z), int'(last_z));
    stall_prev = exp_ov && !b.out_ready && !rst;
    last_z     = b.out_z;
    rst_prev   = rst;
    if (rst) begin
      q.delete();
    end else begin
      if (exp_ov && b.out_ready) void'(q.pop_front());
      for (int k = 0; k < q.size(); k++) q[k].age = (k == 0) ? 2 : 1;
      if (exp_fire) begin
        it.prod = gf_ref(unmask3(b.in_x), unmask3(b.in_y));
        it.age  = 1;
        q.push_back(it);
      end
    end
  end

  int acc = 0, outs = 0, rrs = 0, irlow = 0;

  task automatic cyc();
    @(negedge clk);
    acc   += int'(b.in_valid & b.in_ready);
    outs  += int'(b.out_valid & b.out_ready);
    rrs   += int'(b.rnd_ready);
    irlow += int'(!b.in_ready);
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] s0, s1, u0, u1;
    s0 = 4'($urandom); s1 = 4'($urandom);
    u0 = 4'($urandom); u1 = 4'($urandom);
    b.in_x = {x ^ s0 ^ s1, s1, s0};
    b.in_y = {y ^ u0 ^ u1, u1, u0};
    b.rnd  = 12'($urandom);
  endtask

  task automatic do_op(input logic [3:0] x, input logic [3:0] y, output logic [3:0] zu);
    logic got;
    set_ops(x, y);
    b.in_valid = 1'b1; b.rnd_valid = 1'b1; b.out_ready = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk); got = b.in_ready; @(posedge clk); #1;
    end
    b.in_valid = 1'b0;
    check("accept_timeout", int'(got), 1);
    got = 1'b0; zu = '0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      if (b.out_valid) begin got = 1'b1; zu = unmask3(b.out_z); end
      @(posedge clk); #1;
    end
    check("result_timeout", int'(got), 1);
  endtask

  initial begin
    logic [3:0] zu;
    b.in_valid = 0; b.rnd_valid = 0; b.out_ready = 0; b.in_x = '0; b.in_y = '0; b.rnd = '0;
    b2.in_valid = 0; b2.rnd_valid = 0; b2.out_ready = 1; b2.in_x = '0; b2.in_y = '0; b2.rnd = '0;
    rst = 1'b1;
    b.in_valid = 1; b.rnd_valid = 1;   // nothing may be accepted while in reset
    repeat (3) cyc();
    b.in_valid = 0;
    rst = 1'b0;

    // 2 shares: x = 5^6 = 3, y = A^D = 7, rnd = 4 -> 3*7 = 9
    b2.in_valid = 1; b2.rnd_valid = 1; b2.in_x = 8'h65; b2.in_y = 8'hDA; b2.rnd = 4'h4;
    @(negedge clk);
    check("s2_in_ready", int'(b2.in_ready), 1);
    check("s2_rnd_ready", int'(b2.rnd_ready), 1);
    @(posedge clk); #1;
    b2.in_valid = 0; b2.rnd_valid = 0;
    @(negedge clk);
    check("s2_lat1_out_valid", int'(b2.out_valid), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("s2_lat2_out_valid", int'(b2.out_valid), 1);
    check("s2_product", int'(b2.out_z[3:0] ^ b2.out_z[7:4]), 4'h9);
    @(posedge clk); #1;
    @(negedge clk);
    check("s2_single_result", int'(b2.out_valid), 0);
    @(posedge clk); #1;

    // 3 shares, hand-computed products
    do_op(4'h8, 4'h2, zu); check("s3_8x2", int'(zu), 4'h3);
    do_op(4'hF, 4'hF, zu); check("s3_FxF", int'(zu), 4'hA);
    do_op(4'h0, 4'hB, zu); check("s3_0xB", int'(zu), 4'h0);
    do_op(4'h1, 4'hC, zu); check("s3_1xC", int'(zu), 4'hC);

    // 1000 random ops under random flow control; model checks every cycle
    acc = 0;
    for (int n = 0; n < 6000 && acc < 1000; n++) begin
      set_ops(4'($urandom), 4'($urandom));
      b.in_valid  = ($urandom_range(0, 3) != 0);
      b.rnd_valid = ($urandom_range(0, 3) != 0);
      b.out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    check("random_accepted", acc, 1000);
    b.in_valid = 0; b.out_ready = 1; b.rnd_valid = 1;
    repeat (4) cyc();

    // Streaming: 16 back-to-back ops
    acc = 0; outs = 0; irlow = 0;
    b.in_valid = 1; b.rnd_valid = 1; b.out_ready = 1;
    for (int n = 0; n < 16; n++) begin set_ops(4'($urandom), 4'($urandom)); cyc(); end
    check("stream_accepted", acc, 16);
    check("stream_in_ready_low", irlow, 0);
    b.in_valid = 0;
    repeat (2) cyc();
    check("stream_results", outs, 16);
    repeat (2) cyc();

    // Back-pressure: two items park, input stalls
    acc = 0; irlow = 0; outs = 0;
    b.out_ready = 0; b.in_valid = 1; b.rnd_valid = 1;
    repeat (5) begin set_ops(4'($urandom), 4'($urandom)); cyc(); end
    check("bp_accepted", acc, 2);
    check("bp_in_ready_low_cycles", irlow, 3);
    b.in_valid = 0; b.out_ready = 1;
    repeat (4) cyc();
    check("bp_released_results", outs, 2);

    // No randomness -> no accept; then exactly one accept
    acc = 0; rrs = 0;
    b.rnd_valid = 0; b.in_valid = 1; set_ops(4'h6, 4'h9);
    repeat (3) cyc();
    check("nornd_accepted", acc, 0);
    check("nornd_rnd_ready", rrs, 0);
    b.rnd_valid = 1;
    cyc();
    b.in_valid = 0;
    repeat (3) cyc();
    check("rnd_accepted", acc, 1);
    check("rnd_ready_pulses", rrs, 1);

    // Reset with both stages full
    acc = 0;
    b.out_ready = 0; b.in_valid = 1; b.rnd_valid = 1;
    repeat (3) begin set_ops(4'($urandom), 4'($urandom)); cyc(); end
    b.in_valid = 0;
    check("full_before_reset", acc, 2);
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_ready", int'(b.in_ready), 0);
    check("rst_rnd_ready", int'(b.rnd_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_out_valid", int'(b.out_valid), 0);
    check("post_rst_out_z", int'(b.out_z), 0);
    @(posedge clk); #1;
    outs = 0;
    b.out_ready = 1; b.in_valid = 1; set_ops(4'h5, 4'h5);
    cyc();
    b.in_valid = 0;
    cyc();
    check("post_rst_lat1", outs, 0);
    cyc();
    check("post_rst_lat2", outs, 1);
    repeat (4) cyc();
    check("post_rst_no_stale", outs, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
